// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA timing definitions for the sync generator and the graphic blocks
// that consume its pixel coordinates.
//   - DEF_* : default 640x480@60 timing (pixels / lines)
//   - DEF_H_TOTAL / DEF_V_TOTAL : derived line and frame lengths
//   - COORD_W / coord_t : width and type of pixel_x / pixel_y
//   - in_range() : inclusive range test used for sync pulse decoding
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_RETRACE = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_RETRACE = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_RETRACE + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_RETRACE + DEF_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// vga_tick_div
// Pixel-rate divider: counts 0..TICK_DIV-1 on every clk and raises p_tick
// during the clk where the count is TICK_DIV-1.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   p_tick out one-clk pulse per pixel period (held 0 in reset)
module vga_tick_div #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Gating with reset keeps p_tick low while held in reset; with TICK_DIV=1
  // the count is always LAST, so p_tick is high from the moment reset lifts.
  assign p_tick = reset & (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// 640x480@60 VGA timing generator feeding the pong graphic generator and the
// VGA pins. Counters run through blanking so every coordinate is visible.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   hsync      out  horizontal sync, active-low, registered
//   vsync      out  vertical sync, active-low, registered
//   video_on   out  high inside the visible area (combinational from counts)
//   p_tick     out  one-clk pulse per pixel period
//   pixel_x    out  horizontal count 0..H_TOTAL-1
//   pixel_y    out  vertical count 0..V_TOTAL-1
//   frame_tick out  (only with VGA_FRAME_TICK_EN defined) pulses with the
//                   p_tick that wraps (H_TOTAL-1,V_TOTAL-1) to (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_RETRACE = DEF_H_RETRACE,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_RETRACE = DEF_V_RETRACE,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int TICK_DIV  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
`ifdef VGA_FRAME_TICK_EN
  output logic               frame_tick,
`endif
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  coord_t h_count, v_count;
  coord_t h_next, v_next;
  logic   h_wrap;

  vga_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    h_wrap = (h_count == H_LAST);
    if (p_tick) begin
      h_next = h_wrap ? '0 : h_count + 1'b1;
      if (h_wrap) begin
        v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
    end
  end

  // Syncs are decoded from the next-count values so that, once registered,
  // they line up with the pixel_x/pixel_y they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      hsync   <= ~in_range(h_next, HS_FIRST, HS_LAST);
      vsync   <= ~in_range(v_next, VS_FIRST, VS_LAST);
    end
  end

  assign video_on = (h_count < H_VIS) && (v_count < V_VIS);
  assign pixel_x  = h_count;
  assign pixel_y  = v_count;

`ifdef VGA_FRAME_TICK_EN
  logic frame_wrap;
  assign frame_wrap = h_wrap && (v_count == V_LAST);
  assign frame_tick = p_tick & frame_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Scoreboard bench for vga_sync_gen. Instance A (TICK_DIV=2) keeps the
// default horizontal timing but a shortened vertical frame (12 visible lines,
// 3 front, 2 retrace, 4 back -> 21 lines, vsync on lines 15..16) so a whole
// frame fits in a short run. Instance B uses TICK_DIV=1.
// Define VGA_FRAME_TICK_EN to also exercise frame_tick.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset_b;
  logic       hsync, vsync, video_on, p_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       hsync_b, vsync_b, video_on_b, p_tick_b;
  logic [9:0] pixel_x_b, pixel_y_b;
`ifdef VGA_FRAME_TICK_EN
  logic       frame_tick, frame_tick_b;
`endif

  vga_sync_gen #(
    .V_DISPLAY (12), .V_FRONT (3), .V_RETRACE (2), .V_BACK (4), .TICK_DIV (2)
  ) dut (
    .clk (clk), .reset (reset), .hsync (hsync), .vsync (vsync),
    .video_on (video_on), .p_tick (p_tick),
`ifdef VGA_FRAME_TICK_EN
    .frame_tick (frame_tick),
`endif
    .pixel_x (pixel_x), .pixel_y (pixel_y)
  );

  vga_sync_gen #(
    .V_DISPLAY (12), .V_FRONT (3), .V_RETRACE (2), .V_BACK (4), .TICK_DIV (1)
  ) dut_b (
    .clk (clk), .reset (reset_b), .hsync (hsync_b), .vsync (vsync_b),
    .video_on (video_on_b), .p_tick (p_tick_b),
`ifdef VGA_FRAME_TICK_EN
    .frame_tick (frame_tick_b),
`endif
    .pixel_x (pixel_x_b), .pixel_y (pixel_y_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          n_row13 = 0;
  int          n00 = 0;
  int          t0 = 0, t1 = 0;
  int          ft_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected {pixel_x, pixel_y, hsync, vsync, video_on} for a coordinate.
  function automatic logic [22:0] pix_exp(input int x, input int y);
    logic hs, vs, von;
    hs  = !(x >= 656 && x <= 751);
    vs  = !(y >= 15 && y <= 16);
    von = (x < 640) && (y < 12);
    return {x[9:0], y[9:0], hs, vs, von};
  endfunction

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops one expected pixel per p_tick while enabled.
  initial begin
    logic [22:0] exp_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && reset) begin
        if (pixel_x == 10'd0 && pixel_y == 10'd13) n_row13++;
        if (p_tick) begin
          if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
            if (n00 == 0) t0 = cyc;
            else if (n00 == 1) t1 = cyc;
            n00++;
          end
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            exp_v = exp_q.pop_front();
            check("pix", {9'd0, pixel_x, pixel_y, hsync, vsync, video_on}, {9'd0, exp_v});
          end
        end
`ifdef VGA_FRAME_TICK_EN
        if (frame_tick) begin
          ft_cnt++;
          check("ft_pos", {11'd0, p_tick, pixel_x, pixel_y}, {11'd0, 1'b1, 10'd799, 10'd20});
        end
`endif
      end
    end
  end

  // Stimulus
  initial begin
    logic found;
    reset   = 1'b0;
    reset_b = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_px", 32'(pixel_x), 32'd0);
    check("rst_py", 32'(pixel_y), 32'd0);
    check("rst_hs", 32'(hsync), 32'd1);
    check("rst_vs", 32'(vsync), 32'd1);
    check("rst_ptick", 32'(p_tick), 32'd0);
    check("rst_von", 32'(video_on), 32'd1);
    check("rst_ptick_b", 32'(p_tick_b), 32'd0);
    repeat (2) @(posedge clk);

    // Release and run a full frame plus two pixels
    #1 reset = 1'b1;
    for (int i = 0; i < 800 * 21 + 2; i++) exp_q.push_back(pix_exp(i % 800, (i / 800) % 21));
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ptick_seq", 32'(p_tick), 32'(k % 2));
    end
    wait_drain(40000);
    mon_en = 1'b0;
    check("row13_x0_clks", 32'(n_row13), 32'd2);
    check("frame_period", 32'(t1 - t0), 32'd33600);
`ifdef VGA_FRAME_TICK_EN
    check("ft_count", 32'(ft_cnt), 32'd1);
`endif

    // Mid-frame reset inside both sync pulses
    found = 1'b0;
    for (int c = 0; c < 30000 && !found; c++) begin
      @(negedge clk);
      if (pixel_x == 10'd700 && pixel_y == 10'd15) found = 1'b1;
    end
    check("reach_700_15", 32'(found), 32'd1);
    check("mid_hs", 32'(hsync), 32'd0);
    check("mid_vs", 32'(vsync), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_px", 32'(pixel_x), 32'd0);
    check("async_py", 32'(pixel_y), 32'd0);
    check("async_hs", 32'(hsync), 32'd1);
    check("async_vs", 32'(vsync), 32'd1);
    check("async_ptick", 32'(p_tick), 32'd0);
    check("async_von", 32'(video_on), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 802; i++) exp_q.push_back(pix_exp(i % 800, i / 800));
    mon_en = 1'b1;
    wait_drain(2000);
    mon_en = 1'b0;

    // TICK_DIV=1: p_tick always high, one pixel per clk, 800-clk line
    @(posedge clk);
    #1 reset_b = 1'b1;
    begin
      int b_low;
      b_low = 0;
      for (int k = 0; k < 801; k++) begin
        @(negedge clk);
        if (!p_tick_b) b_low++;
        if (k < 4 || k == 799 || k == 800) begin
          check("b_px", 32'(pixel_x_b), 32'(k % 800));
          check("b_py", 32'(pixel_y_b), (k == 800) ? 32'd1 : 32'd0);
          check("b_von", 32'(video_on_b), (k < 4 || k == 800) ? 32'd1 : 32'd0);
          check("b_vs", 32'(vsync_b), 32'd1);
`ifdef VGA_FRAME_TICK_EN
          check("b_ft", 32'(frame_tick_b), 32'd0);
`endif
        end
        if (k == 700) check("b_hs", 32'(hsync_b), 32'd0);
      end
      check("b_ptick_low_clks", 32'(b_low), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
